// File: rtl/kb_line_editor.sv
// Keyboard line editor: gathers key codes into an edit buffer with backspace/escape/overflow
// handling, and commits finished lines to a registered valid/ready output slot.
module kb_line_editor #(
  parameter int                 MAX_LEN   = 16,
  parameter int                 CHAR_W    = 8,
  parameter logic [CHAR_W-1:0]  PAD_CHAR  = 8'h00,
  parameter logic [CHAR_W-1:0]  KEY_ENTER = 8'h0D,
  parameter logic [CHAR_W-1:0]  KEY_BKSP  = 8'h08,
  parameter logic [CHAR_W-1:0]  KEY_ESC   = 8'h1B,
  localparam int                LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHAR_W-1:0]         key,
  input  logic                      key_valid,
  output logic [MAX_LEN*CHAR_W-1:0] line_out,
  output logic [LW-1:0]             line_len,
  output logic                      line_overflow,
  output logic                      line_valid,
  input  logic                      line_ready,
  output logic [LW-1:0]             cur_len,
  output logic                      busy
);

  typedef enum logic {EMPTY, FULL} out_state_e;

  out_state_e                state_q, state_d;
  logic [CHAR_W-1:0]         buf_q [MAX_LEN];
  logic [CHAR_W-1:0]         buf_d [MAX_LEN];
  logic [LW-1:0]             cur_len_q, cur_len_d;
  logic                      ovf_q, ovf_d;
  logic [MAX_LEN*CHAR_W-1:0] line_out_q, line_out_d;
  logic [LW-1:0]             line_len_q, line_len_d;
  logic                      line_ovf_q, line_ovf_d;
  logic [MAX_LEN*CHAR_W-1:0] packed_buf;
  logic                      commit_ok;
  logic                      commit;

  // Char 0 lands in the MSBs of the committed line.
  always_comb begin
    packed_buf = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      packed_buf[(MAX_LEN-1-i)*CHAR_W +: CHAR_W] = buf_q[i];
    end
  end

  // The slot may refill in the same cycle the consumer drains it.
  assign commit_ok = (state_q == EMPTY) || line_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves a latch.
    state_d    = state_q;
    buf_d      = buf_q;
    cur_len_d  = cur_len_q;
    ovf_d      = ovf_q;
    line_out_d = line_out_q;
    line_len_d = line_len_q;
    line_ovf_d = line_ovf_q;
    commit     = 1'b0;

    if (key_valid) begin
      if (key == KEY_ENTER) begin
        if (commit_ok) begin
          commit     = 1'b1;
          line_out_d = packed_buf;
          line_len_d = cur_len_q;
          line_ovf_d = ovf_q;
          for (int i = 0; i < MAX_LEN; i++) buf_d[i] = PAD_CHAR;
          cur_len_d  = '0;
          ovf_d      = 1'b0;
        end
      end else if (key == KEY_BKSP) begin
        if (cur_len_q != '0) begin
          cur_len_d = cur_len_q - LW'(1);
          for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) == cur_len_d) buf_d[i] = PAD_CHAR;
          end
        end
      end else if (key == KEY_ESC) begin
        for (int i = 0; i < MAX_LEN; i++) buf_d[i] = PAD_CHAR;
        cur_len_d = '0;
        ovf_d     = 1'b0;
      end else begin
        if (cur_len_q < LW'(MAX_LEN)) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) == cur_len_q) buf_d[i] = key;
          end
          cur_len_d = cur_len_q + LW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    case (state_q)
      EMPTY:   if (commit) state_d = FULL;
      FULL:    if (line_ready && !commit) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      // NOTE: the edit buffer is reset, not left undefined, because padding of unused slots is visible in line_out.
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= PAD_CHAR;
      cur_len_q  <= '0;
      ovf_q      <= 1'b0;
      line_out_q <= {MAX_LEN{PAD_CHAR}};
      line_len_q <= '0;
      line_ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      buf_q      <= buf_d;
      cur_len_q  <= cur_len_d;
      ovf_q      <= ovf_d;
      line_out_q <= line_out_d;
      line_len_q <= line_len_d;
      line_ovf_q <= line_ovf_d;
    end
  end

  assign line_out      = line_out_q;
  assign line_len      = line_len_q;
  assign line_overflow = line_ovf_q;
  assign line_valid    = (state_q == FULL);
  assign busy          = (state_q == FULL);
  assign cur_len       = cur_len_q;

endmodule
